batamateur_sequencer: RTL

Parametrised microcode sequencer for the BatAmateur CPU and the next generation of its control unit. It fetches a 16-bit instruction and decodes it into bus control strobes for PC, MAR, RAM, IR, ALU and a configurable register file. It adds four things over the fixed controller: a parametrised register count, a carry-conditioned branch, a HALT instruction, and an optional memory wait handshake. It sits between the datapath and the shared bus and owns every bus enable.

---
 rtl/batamateur_sequencer.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/batamateur_sequencer.sv
// batamateur_sequencer: microcode sequencer for the BatAmateur CPU.
// Fetches a 16-bit instruction and decodes it into bus strobes for the PC, MAR,
// RAM, IR, ALU and a register file of NUM_REGS entries. Outputs are a
// combinational function of state, INSTR and ALU_FLAGS.
// Optional feature: define BATAMATEUR_MEM_WAIT_EN to make every RAM-enabled
// state wait for MEM_RDY.
module batamateur_sequencer #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ALU_OP_W = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [15:0]         INSTR,
  input  logic [1:0]          ALU_FLAGS,
  input  logic                MEM_RDY,
  output logic                PC_INC,
  output logic                PC_RW,
  output logic                PC_EN,
  output logic                MAR_LOAD,
  output logic                MAR_EN,
  output logic                RAM_RW,
  output logic                RAM_EN,
  output logic                IR_LOAD,
  output logic                IR_EN,
  output logic [NUM_REGS-1:0] REGS_INC,
  output logic [NUM_REGS-1:0] REGS_RW,
  output logic [NUM_REGS-1:0] REGS_EN,
  output logic                ALU_EN,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic                HALTED
);

  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [4:0] OPC_MOV  = 5'b11111;
  localparam logic [4:0] OPC_INC  = 5'b11110;
  localparam logic [4:0] OPC_HALT = 5'b11101;

  state_e state_q, state_d;

  // One-hot register select; indices at or above NUM_REGS select nothing.
  function automatic logic [NUM_REGS-1:0] reg_oh(input logic [2:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx == 3'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Instruction field decode. The 0111 register-op space takes precedence
  // over the jump decode that would otherwise also match INSTR[14]=1.
  logic       is_reg, is_mov, is_inc, is_halt, is_alu, is_jmp, is_ls;
  logic       indirect, is_store, jmp_take;
  logic [4:0] opc;
  logic [2:0] dst, src, ls_reg;

  assign opc      = INSTR[11:7];
  assign dst      = INSTR[5:3];
  assign src      = INSTR[2:0];
  assign ls_reg   = {2'b00, INSTR[12]};
  assign indirect = INSTR[15];
  assign is_store = INSTR[13];
  assign is_reg   = (INSTR[15:12] == 4'b0111);
  assign is_mov   = is_reg && (opc == OPC_MOV);
  assign is_inc   = is_reg && (opc == OPC_INC);
  assign is_halt  = is_reg && (opc == OPC_HALT);
  assign is_alu   = is_reg && !is_mov && !is_inc && !is_halt;
  assign is_jmp   = !is_reg && INSTR[14];
  assign is_ls    = !INSTR[14];

  // Branch condition, evaluated live in whichever cycle decides the jump.
  always_comb begin
    jmp_take = 1'b0;
    case (INSTR[13:12])
      2'b00:   jmp_take = 1'b1;
      2'b01:   jmp_take = ALU_FLAGS[0];
      2'b10:   jmp_take = !ALU_FLAGS[0];
      default: jmp_take = ALU_FLAGS[1];
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_T0;
    else     state_q <= state_d;
  end

  // Next-state and strobe decode.
  always_comb begin
    PC_INC   = 1'b0;
    PC_RW    = 1'b1;
    PC_EN    = 1'b0;
    MAR_LOAD = 1'b0;
    MAR_EN   = 1'b1;
    RAM_RW   = 1'b1;
    RAM_EN   = 1'b0;
    IR_LOAD  = 1'b0;
    IR_EN    = 1'b0;
    REGS_INC = '0;
    REGS_RW  = '1;
    REGS_EN  = '0;
    ALU_EN   = 1'b0;
    ALU_OP   = '0;
    HALTED   = 1'b0;
    state_d  = state_q;

    case (state_q)
      S_T0: begin
        PC_EN    = 1'b1;
        MAR_LOAD = 1'b1;
        state_d  = S_T1;
      end
      S_T1: begin
        RAM_EN  = 1'b1;
        IR_LOAD = 1'b1;
        IR_EN   = 1'b1;
        PC_INC  = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        state_d = S_T0;
        if (is_mov) begin
          REGS_EN = reg_oh(src) | reg_oh(dst);
          REGS_RW = ~reg_oh(dst);
        end else if (is_inc) begin
          REGS_INC = reg_oh(dst);
          REGS_RW  = ~reg_oh(dst);
        end else if (is_halt) begin
          state_d = S_HALT;
        end else if (is_alu) begin
          if (dst != 3'd0) begin
            REGS_EN = reg_oh(dst) | reg_oh(3'd0);
            REGS_RW = ~reg_oh(3'd0);
          end
          state_d = S_T3;
        end else if (is_jmp && !indirect) begin
          if (jmp_take) begin
            IR_EN = 1'b1;
            PC_EN = 1'b1;
            PC_RW = 1'b0;
          end else begin
            PC_INC = 1'b1;
          end
        end else begin
          // Indirect jump and all load/store forms latch the operand address.
          IR_EN    = 1'b1;
          MAR_LOAD = 1'b1;
          state_d  = S_T3;
        end
      end
      S_T3: begin
        state_d = S_T0;
        if (is_alu) begin
          if (src != 3'd1) begin
            REGS_EN = reg_oh(src) | reg_oh(3'd1);
            REGS_RW = ~reg_oh(3'd1);
          end
          state_d = S_T4;
        end else if (is_jmp && indirect) begin
          if (jmp_take) begin
            RAM_EN = 1'b1;
            PC_EN  = 1'b1;
            PC_RW  = 1'b0;
          end else begin
            PC_INC = 1'b1;
          end
        end else if (is_ls && indirect) begin
          RAM_EN   = 1'b1;
          MAR_LOAD = 1'b1;
          state_d  = S_T4;
        end else if (is_ls) begin
          RAM_EN = 1'b1;
          if (is_store) begin
            REGS_EN = reg_oh(ls_reg);
            RAM_RW  = 1'b0;
          end else begin
            REGS_EN = reg_oh(ls_reg);
            REGS_RW = ~reg_oh(ls_reg);
          end
        end
      end
      S_T4: begin
        state_d = S_T0;
        if (is_alu) begin
          ALU_EN  = 1'b1;
          ALU_OP  = ALU_OP_W'(opc);
          REGS_EN = reg_oh(INSTR[6] ? 3'd0 : 3'd1);
          REGS_RW = ~REGS_EN;
        end else if (is_ls) begin
          RAM_EN = 1'b1;
          if (is_store) begin
            REGS_EN = reg_oh(ls_reg);
            RAM_RW  = 1'b0;
          end else begin
            REGS_EN = reg_oh(ls_reg);
            REGS_RW = ~reg_oh(ls_reg);
          end
        end
      end
      S_HALT: begin
        HALTED  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_T0;
    endcase

`ifdef BATAMATEUR_MEM_WAIT_EN
    // Hold any RAM cycle until the memory is ready; one-shots fire only once.
    if (RAM_EN && !MEM_RDY) begin
      state_d  = state_q;
      PC_INC   = 1'b0;
      REGS_INC = '0;
    end
`endif

    // Reset forces idle strobes and aborts the instruction in flight.
    if (RST) begin
      PC_INC   = 1'b0;
      PC_RW    = 1'b1;
      PC_EN    = 1'b0;
      MAR_LOAD = 1'b0;
      MAR_EN   = 1'b1;
      RAM_RW   = 1'b1;
      RAM_EN   = 1'b0;
      IR_LOAD  = 1'b0;
      IR_EN    = 1'b0;
      REGS_INC = '0;
      REGS_RW  = '1;
      REGS_EN  = '0;
      ALU_EN   = 1'b0;
      ALU_OP   = '0;
      HALTED   = 1'b0;
      state_d  = S_T0;
    end
  end

`ifndef BATAMATEUR_MEM_WAIT_EN
  // MEM_RDY has no effect without the wait feature.
  logic unused_mem_rdy;
  assign unused_mem_rdy = MEM_RDY;
`endif

endmodule
